// File: rtl/uart_tx_if.sv
// Byte handshake into the UART transmitter: upstream presents tx_data/tx_valid, block answers tx_ready.
// A byte is accepted when tx_valid and tx_ready are both high at a rising clock edge.
interface uart_tx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start + LSB-first data + optional parity + stop bit(s), one bit per tx_en tick.
// Start bit begins on the first tick after accept; tx_ready is high only while idle, so upstream stalls for a whole frame.
module uart_tx #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      tx_en,
    uart_tx_if.slave  tx_if,
    output logic      tx,
    output logic      tx_busy,
    output logic      tx_done
);
    localparam int                CNT_W     = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(DATA_BITS - 1);
    localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t               r_state,    w_state_nxt;
    logic [DATA_BITS-1:0] r_shift,    w_shift_nxt;
    logic                 r_parity,   w_parity_nxt;
    logic [CNT_W-1:0]     r_bit_cnt,  w_bit_cnt_nxt;
    logic                 r_stop_cnt, w_stop_cnt_nxt;
    logic                 r_tx,       w_tx_nxt;
    logic                 r_done,     w_done_nxt;
    logic                 r_ready;
    logic                 r_busy;
    logic                 w_accept;

    assign w_accept       = tx_if.tx_valid & r_ready;
    assign tx_if.tx_ready = r_ready;
    assign tx             = r_tx;
    assign tx_busy        = r_busy;
    assign tx_done        = r_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_tx       <= 1'b1;
            r_done     <= 1'b0;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_parity   <= w_parity_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_stop_cnt <= w_stop_cnt_nxt;
            r_tx       <= w_tx_nxt;
            r_done     <= w_done_nxt;
            r_ready    <= (w_state_nxt == ST_IDLE);
            r_busy     <= (w_state_nxt != ST_IDLE);
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_parity_nxt   = r_parity;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_stop_cnt_nxt = r_stop_cnt;
        w_tx_nxt       = r_tx;
        w_done_nxt     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Ticks are ignored here; LOAD waits for the next one so the start bit is grid-aligned.
                if (w_accept) begin
                    w_shift_nxt  = tx_if.tx_data;
                    w_parity_nxt = (PARITY_ODD != 0) ? ~^tx_if.tx_data : ^tx_if.tx_data;
                    w_state_nxt  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (tx_en) begin
                    w_tx_nxt    = 1'b0;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (tx_en) begin
                    w_tx_nxt      = r_shift[0];
                    w_bit_cnt_nxt = '0;
                    w_state_nxt   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tx_en) begin
                    if (r_bit_cnt == BIT_LAST) begin
                        if (PARITY_EN != 0) begin
                            w_tx_nxt    = r_parity;
                            w_state_nxt = ST_PARITY;
                        end else begin
                            w_tx_nxt       = 1'b1;
                            w_stop_cnt_nxt = 1'b0;
                            w_state_nxt    = ST_STOP;
                        end
                    end else begin
                        w_shift_nxt   = r_shift >> 1;
                        w_tx_nxt      = r_shift[1];
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (tx_en) begin
                    w_tx_nxt       = 1'b1;
                    w_stop_cnt_nxt = 1'b0;
                    w_state_nxt    = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tx_en) begin
                    if (r_stop_cnt == STOP_LAST) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_stop_cnt_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_tx_nxt    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four instances (8N1, 8E1, 8O1, 8N2) share clock, reset and a tick every 16 clk.
// Line, tx_done, tx_busy and tx_ready are sampled 1 ns after every tick edge and compared to hand-derived frames.
module tb_uart_tx;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic tx_en = 1'b0;

    logic [7:0] data_q  [4];
    logic       valid_q [4];
    logic       ready_w [4];
    logic       tx_w    [4];
    logic       busy_w  [4];
    logic       done_w  [4];
    int         done_cnt[4];

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    uart_tx_if #(.DATA_BITS(8)) if0 ();
    uart_tx_if #(.DATA_BITS(8)) if1 ();
    uart_tx_if #(.DATA_BITS(8)) if2 ();
    uart_tx_if #(.DATA_BITS(8)) if3 ();

    assign if0.tx_data = data_q[0];  assign if0.tx_valid = valid_q[0];  assign ready_w[0] = if0.tx_ready;
    assign if1.tx_data = data_q[1];  assign if1.tx_valid = valid_q[1];  assign ready_w[1] = if1.tx_ready;
    assign if2.tx_data = data_q[2];  assign if2.tx_valid = valid_q[2];  assign ready_w[2] = if2.tx_ready;
    assign if3.tx_data = data_q[3];  assign if3.tx_valid = valid_q[3];  assign ready_w[3] = if3.tx_ready;

    uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .reset(reset), .tx_en(tx_en), .tx_if(if0.slave),
        .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));
    uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .reset(reset), .tx_en(tx_en), .tx_if(if1.slave),
        .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]));
    uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .reset(reset), .tx_en(tx_en), .tx_if(if2.slave),
        .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]));
    uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_8n2 (
        .clk(clk), .reset(reset), .tx_en(tx_en), .tx_if(if3.slave),
        .tx(tx_w[3]), .tx_busy(busy_w[3]), .tx_done(done_w[3]));

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (done_w[i]) done_cnt[i] <= done_cnt[i] + 1;
        end
    end

    initial begin
        forever begin
            repeat (15) @(negedge clk);
            tx_en = 1'b1;
            @(negedge clk);
            tx_en = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_tick();
        int n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (!tx_en && n < 40);
        if (!tx_en) check("tick_timeout", {31'd0, tx_en}, 32'd1);
        #1;
    endtask

    task automatic wait_ready(input int idx);
        int n = 0;
        while (!ready_w[idx] && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("ready_timeout", {31'd0, ready_w[idx]}, 32'd1);
    endtask

    // Present a byte, wait for acceptance, then scramble tx_data to prove it was latched.
    task automatic send(input int idx, input logic [7:0] d);
        @(negedge clk);
        data_q[idx]  = d;
        valid_q[idx] = 1'b1;
        wait_ready(idx);
        @(negedge clk);
        valid_q[idx] = 1'b0;
        data_q[idx]  = ~d;
    endtask

    task automatic check_frame(input int idx, input logic [7:0] d, input int p_en,
                               input logic p_bit, input int s);
        int   total;
        logic exp_tx;
        total = 8 + p_en + s + 2;
        for (int k = 1; k <= total; k++) begin
            wait_tick();
            if (k == 1)                     exp_tx = 1'b0;
            else if (k <= 9)                exp_tx = d[k-2];
            else if (k == 10 && p_en != 0)  exp_tx = p_bit;
            else                            exp_tx = 1'b1;
            check("tx_line", {31'd0, tx_w[idx]}, {31'd0, exp_tx});
            check("tx_done", {31'd0, done_w[idx]}, {31'd0, (k == total)});
            if (k < total) begin
                check("busy_mid", {31'd0, busy_w[idx]}, 32'd1);
                check("ready_mid", {31'd0, ready_w[idx]}, 32'd0);
            end
        end
        check("ready_end", {31'd0, ready_w[idx]}, 32'd1);
        check("busy_end", {31'd0, busy_w[idx]}, 32'd0);
    endtask

    initial begin
        int c0;
        for (int i = 0; i < 4; i++) begin
            data_q[i]  = 8'h00;
            valid_q[i] = 1'b0;
        end

        // Reset asserted while idle
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        reset = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("rst_tx", {31'd0, tx_w[i]}, 32'd1);
            check("rst_ready", {31'd0, ready_w[i]}, 32'd1);
            check("rst_busy", {31'd0, busy_w[i]}, 32'd0);
            check("rst_done", {31'd0, done_w[i]}, 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;

        // 8N1 0xA5: 0,1,0,1,0,0,1,0,1,1 and exactly one done pulse
        c0 = done_cnt[0];
        send(0, 8'hA5);
        check_frame(0, 8'hA5, 0, 1'b0, 1);
        repeat (2) @(negedge clk);
        check("done_count_a5", done_cnt[0] - c0, 32'd1);

        // Parity on 0x07 (three ones): even -> 1, odd -> 0
        send(1, 8'h07);
        check_frame(1, 8'h07, 1, 1'b1, 1);
        send(2, 8'h07);
        check_frame(2, 8'h07, 1, 1'b0, 1);

        // Two stop bits on 0x00
        send(3, 8'h00);
        check_frame(3, 8'h00, 0, 1'b0, 2);

        // Back-to-back with tx_valid held: 0x55 then 0x0F, no idle gap
        @(negedge clk);
        data_q[0]  = 8'h55;
        valid_q[0] = 1'b1;
        wait_ready(0);
        @(negedge clk);
        data_q[0] = 8'h0F;
        check_frame(0, 8'h55, 0, 1'b0, 1);
        @(negedge clk);
        @(negedge clk);
        valid_q[0] = 1'b0;
        check_frame(0, 8'h0F, 0, 1'b0, 1);

        // Reset during data bit 3 of 0xFF aborts the frame without tx_done
        send(0, 8'hFF);
        repeat (5) wait_tick();
        repeat (4) @(negedge clk);
        c0 = done_cnt[0];
        reset = 1'b1;
        #1;
        check("abort_tx", {31'd0, tx_w[0]}, 32'd1);
        check("abort_busy", {31'd0, busy_w[0]}, 32'd0);
        check("abort_ready", {31'd0, ready_w[0]}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            wait_tick();
            check("abort_idle_tx", {31'd0, tx_w[0]}, 32'd1);
            check("abort_no_done", {31'd0, done_w[0]}, 32'd0);
        end
        check("abort_done_count", done_cnt[0] - c0, 32'd0);
        send(0, 8'hA5);
        check_frame(0, 8'hA5, 0, 1'b0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
